// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path.
//   BYTE_W       : width of one UART data byte
//   txq_state_t  : output FSM states of uart_tx_queue
// Optional feature macro: UART_TXQ_GAP_EN adds the GAP state.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1
`ifdef UART_TXQ_GAP_EN
        ,
        ST_GAP     = 2'd2
`endif
    } txq_state_t;

endpackage

// File: rtl/uart_txq_mem.sv
// ---------------------------------------------------------------------------
// uart_txq_mem
// Simple dual-port DEPTH x BYTE_W register array: synchronous write,
// combinational read. Contents are not reset; occupancy is tracked outside.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write byte
//   raddr  in   read address
//   rdata  out  byte stored at raddr
// ---------------------------------------------------------------------------
module uart_txq_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [BYTE_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [BYTE_W-1:0] rdata
);

    logic [BYTE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_queue.sv
// ---------------------------------------------------------------------------
// uart_tx_queue
// Transmit byte queue in front of the UART transmitter. Host write strobes
// are buffered in a circular FIFO and handed to the transmitter one byte at
// a time through a registered valid/ready output stage.
// Optional feature macro: UART_TXQ_GAP_EN -- when defined, GAP_CYCLES idle
// cycles are inserted after every handshake (GAP_CYCLES = 0 disables it).
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   wr_en     in   host write strobe
//   wr_data   in   byte to enqueue
//   clr_ovf   in   clear the sticky overflow flag
//   tx_data   out  byte presented to the transmitter
//   tx_valid  out  tx_data is valid
//   tx_ready  in   transmitter accepts tx_data
//   count     out  FIFO memory occupancy (output register excluded)
//   empty     out  nothing in memory and nothing presented
//   afull     out  count >= AFULL_LEVEL
//   overflow  out  sticky: a write was dropped
// ---------------------------------------------------------------------------
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int AFULL_LEVEL = 12,
    parameter int GAP_CYCLES  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [BYTE_W-1:0]        wr_data,
    input  logic                     clr_ovf,
    output logic [BYTE_W-1:0]        tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     afull,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    txq_state_t        state;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_q;
    logic [BYTE_W-1:0] rd_data;

    logic has_data;
    logic full;
    logic hs;
    logic gap_go;
    logic load;
    logic wr_acc;
    logic drop;

    assign has_data = (count_q != '0);
    assign full     = (count_q == CW'(DEPTH));
    assign hs       = tx_valid && tx_ready;

`ifdef UART_TXQ_GAP_EN
    logic [15:0] gap_cnt;
    assign gap_go = hs && (GAP_CYCLES != 0);
`else
    logic unused_gap_cycles;
    assign unused_gap_cycles = (GAP_CYCLES != 0);
    assign gap_go            = 1'b0;
`endif

    // A load pulls mem[rd_ptr] into the output register: from IDLE, or as a
    // back-to-back reload on a handshake that is not followed by a gap.
    assign load = has_data &&
                  ((state == ST_IDLE) || ((state == ST_PRESENT) && hs && !gap_go));

    // A load in the same cycle frees a slot, so a write to a full FIFO is
    // still accepted then (the old entry is read before the edge overwrites it).
    assign wr_acc = wr_en && (!full || load);
    assign drop   = wr_en && !wr_acc;

    uart_txq_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            count_q <= count_q + CW'(wr_acc) - CW'(load);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            rd_ptr   <= '0;
`ifdef UART_TXQ_GAP_EN
            gap_cnt  <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        tx_data  <= rd_data;
                        rd_ptr   <= rd_ptr + 1'b1;
                        tx_valid <= 1'b1;
                        state    <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (hs) begin
`ifdef UART_TXQ_GAP_EN
                        if (gap_go) begin
                            gap_cnt  <= 16'(GAP_CYCLES - 1);
                            tx_valid <= 1'b0;
                            state    <= ST_GAP;
                        end else
`endif
                        if (load) begin
                            tx_data <= rd_data;
                            rd_ptr  <= rd_ptr + 1'b1;
                        end else begin
                            tx_valid <= 1'b0;
                            state    <= ST_IDLE;
                        end
                    end
                end
`ifdef UART_TXQ_GAP_EN
                ST_GAP: begin
                    if (gap_cnt == 16'd0) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end
                end
`endif
                default: begin
                    tx_valid <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign count = count_q;
    assign empty = !has_data && !tx_valid;
    assign afull = (count_q >= CW'(AFULL_LEVEL));

endmodule

// File: tb/tb_uart_tx_queue.sv
module tb_uart_tx_queue;

    localparam int DEPTH = 16;
    localparam int AFULL = 12;
`ifdef UART_TXQ_GAP_EN
    localparam int GAP = 3;
`else
    localparam int GAP = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       clr_ovf;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [4:0] count;
    logic       empty;
    logic       afull;
    logic       overflow;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    uart_tx_queue #(
        .DEPTH       (DEPTH),
        .AFULL_LEVEL (AFULL),
        .GAP_CYCLES  (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .clr_ovf  (clr_ovf),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .count    (count),
        .empty    (empty),
        .afull    (afull),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: memory contents as a queue, plus the presented byte.
    logic [7:0] mq[$];
    logic [7:0] acc_log[$];
    logic [7:0] sent[$];
    bit         m_valid;
    logic [7:0] m_byte;
    int         m_gap;
    bit         m_ovf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_valid = 0;
            m_byte  = 8'h00;
            m_gap   = -1;
            m_ovf   = 0;
        end else begin
            bit hs, full, ld, acc;
            hs   = m_valid && tx_ready;
            full = (mq.size() == DEPTH);
            ld   = (mq.size() > 0) && ((!m_valid && m_gap < 0) || (hs && GAP == 0));
            acc  = wr_en && (!full || ld);
            if (ld) begin
                m_byte  = mq.pop_front();
                m_valid = 1;
            end else if (hs) begin
                m_valid = 0;
                if (GAP > 0) m_gap = GAP - 1;
            end else if (m_gap == 0) begin
                m_gap = -1;
            end else if (m_gap > 0) begin
                m_gap--;
            end
            if (acc) begin
                mq.push_back(wr_data);
                acc_log.push_back(wr_data);
            end
            if (wr_en && !acc) m_ovf = 1;
            else if (clr_ovf) m_ovf = 0;
        end
    end

    // Bytes actually handed over by the DUT (values just before the edge).
    always @(posedge clk) begin
        if (!rst && tx_valid && tx_ready) sent.push_back(tx_data);
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst && chk_en) begin
            check("cyc_tx_valid", 32'(tx_valid), 32'(m_valid));
            check("cyc_tx_data", 32'(tx_data), 32'(m_byte));
            check("cyc_count", 32'(count), 32'(mq.size()));
            check("cyc_empty", 32'(empty), 32'((mq.size() == 0) && !m_valid));
            check("cyc_afull", 32'(afull), 32'(mq.size() >= AFULL));
            check("cyc_overflow", 32'(overflow), 32'(m_ovf));
        end
    end

    initial begin
        int nw;
        rst = 1; wr_en = 0; wr_data = 0; clr_ovf = 0; tx_ready = 0;
        repeat (3) @(negedge clk);
        check("rst_tx_valid", 32'(tx_valid), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_afull", 32'(afull), 0);
        check("rst_overflow", 32'(overflow), 0);
        rst = 0;
        chk_en = 1;

        // Single byte: latency 2, handshake on the next edge
        tx_ready = 1; wr_en = 1; wr_data = 8'hA5;
        @(negedge clk); wr_en = 0;
        check("a5_count_n", 32'(count), 1);
        check("a5_valid_n", 32'(tx_valid), 0);
        @(negedge clk);
        check("a5_valid_n1", 32'(tx_valid), 1);
        check("a5_data_n1", 32'(tx_data), 32'hA5);
        @(negedge clk);
        check("a5_valid_n2", 32'(tx_valid), 0);
        check("a5_empty_n2", 32'(empty), 1);

        // Fill with 18 bytes while stalled
        tx_ready = 0;
        sent.delete();
        for (int i = 0; i < 18; i++) begin
            wr_en = 1; wr_data = 8'(i);
            @(negedge clk);
        end
        wr_en = 0;
        check("fill_count", 32'(count), 16);
        check("fill_afull", 32'(afull), 1);
        check("fill_overflow", 32'(overflow), 1);
        check("fill_tx_data", 32'(tx_data), 0);
        check("fill_tx_valid", 32'(tx_valid), 1);
        clr_ovf = 1;
        @(negedge clk); clr_ovf = 0;
        check("clr_overflow", 32'(overflow), 0);

        // Write while full in the same cycle as a load
        tx_ready = 1; wr_en = 1; wr_data = 8'h55;
        @(negedge clk); wr_en = 0;
        check("full_ld_count", 32'(count), 16);
        check("full_ld_overflow", 32'(overflow), 0);
        check("full_ld_tx_data", 32'(tx_data), 1);
        for (int k = 0; k < 60 && sent.size() < 18; k++) @(negedge clk);
        check("drain_len", 32'(sent.size()), 18);
        for (int i = 0; i < 18; i++) begin
            logic [7:0] exp_b;
            exp_b = (i == 17) ? 8'h55 : 8'(i);
            if (i < sent.size()) check("drain_byte", 32'(sent[i]), 32'(exp_b));
        end

        // Random stream, pointer wrap
        acc_log.delete();
        sent.delete();
        nw = 0;
        for (int k = 0; k < 1000 && nw < 40; k++) begin
            wr_en    = ($urandom_range(0, 1) == 1);
            wr_data  = 8'($urandom);
            tx_ready = ($urandom_range(0, 1) == 1);
            if (wr_en) nw++;
            @(negedge clk);
        end
        wr_en = 0; tx_ready = 1;
        for (int k = 0; k < 200 && (mq.size() > 0 || m_valid || m_gap >= 0); k++) @(negedge clk);
        check("rand_drained", 32'(mq.size() == 0 && !m_valid), 1);
        check("rand_len", 32'(sent.size()), 32'(acc_log.size()));
        for (int i = 0; i < acc_log.size(); i++) begin
            if (i < sent.size()) check("rand_byte", 32'(sent[i]), 32'(acc_log[i]));
        end

`ifdef UART_TXQ_GAP_EN
        // Gap of 3 cycles between two bytes
        tx_ready = 1; wr_en = 1; wr_data = 8'h11;
        @(negedge clk); wr_data = 8'h22;
        @(negedge clk); wr_en = 0;
        @(negedge clk);
        check("gap_valid_h0", 32'(tx_valid), 0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("gap_valid_low", 32'(tx_valid), 0);
        end
        @(negedge clk);
        check("gap_valid_h4", 32'(tx_valid), 1);
        check("gap_data_h4", 32'(tx_data), 32'h22);
        repeat (2) @(negedge clk);
`endif

        // Reset mid-transfer
        tx_ready = 0;
        for (int i = 0; i < 6; i++) begin
            wr_en = 1; wr_data = 8'(8'h80 + i);
            @(negedge clk);
        end
        wr_en = 0;
        @(negedge clk);
        check("pre_rst_valid", 32'(tx_valid), 1);
        check("pre_rst_count", 32'(count), 5);
        #2 rst = 1;
        #1;
        check("mid_rst_tx_valid", 32'(tx_valid), 0);
        check("mid_rst_tx_data", 32'(tx_data), 0);
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_empty", 32'(empty), 1);
        check("mid_rst_overflow", 32'(overflow), 0);
        @(negedge clk);
        rst = 0; tx_ready = 1; wr_en = 1; wr_data = 8'h3C;
        @(negedge clk); wr_en = 0;
        @(negedge clk);
        check("post_rst_valid", 32'(tx_valid), 1);
        check("post_rst_data", 32'(tx_data), 32'h3C);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
